// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS control path.
package multicycle_ctrl_pkg;

   // Opcodes handled by the main decoder
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_J     = 6'b000010;

   // ALU operation codes; ALU_NO_USE hands control to the funct decoder
   localparam logic [2:0] ALU_ADD    = 3'd1;
   localparam logic [2:0] ALU_SUB    = 3'd2;
   localparam logic [2:0] ALU_AND    = 3'd3;
   localparam logic [2:0] ALU_OR     = 3'd4;
   localparam logic [2:0] ALU_SLT    = 3'd5;
   localparam logic [2:0] ALU_NO_USE = 3'd7;

   // PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // ALU B operand select
   localparam logic [1:0] ALUB_REGB  = 2'b00;
   localparam logic [1:0] ALUB_FOUR  = 2'b01;
   localparam logic [1:0] ALUB_IMM   = 2'b10;
   localparam logic [1:0] ALUB_IMMSH = 2'b11;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTEXE   = 4'd6,
      RTWB    = 4'd7,
      BEQ     = 4'd8,
      IMMEXE  = 4'd9,
      IMMWB   = 4'd10,
      JUMP    = 4'd11,
      ILLEGAL = 4'd12
   } ctrl_state_t;

endpackage

// File: rtl/multicycle_ctrl_imm_aluop_dec.sv
// ALU operation for the immediate-execute state, selected by opcode.
module imm_aluop_dec
   import multicycle_ctrl_pkg::*;
(
   input  logic [5:0] op,
   output logic [2:0] aluop
);

   // Map immediate opcodes to their ALU operation; addition is the fallback
   always_comb begin
      aluop = ALU_ADD;
      case (op)
         OP_ORI:  aluop = ALU_OR;
         OP_ANDI: aluop = ALU_AND;
         OP_SLTI: aluop = ALU_SLT;
         default: aluop = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM sequencing the multi-cycle MIPS datapath.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       memwrite,
   output logic       iord,
   output logic       irwrite,
   output logic       pc_en,
   output logic [1:0] pcsrc,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [2:0] aluop,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       retire,
   output logic       illegal,
   output logic [3:0] state_o
);

   ctrl_state_t state, state_nxt;
   logic [2:0]  imm_aluop;

   imm_aluop_dec u_imm_aluop_dec (
      .op    (op),
      .aluop (imm_aluop)
   );

   assign state_o = state;

   // State register; reset aborts any instruction back to fetch
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= FETCH;
      else         state <= state_nxt;
   end

   // Next-state and output decode; everything is suppressed while in reset
   always_comb begin
      state_nxt = state;
      mem_req   = 1'b0;
      memwrite  = 1'b0;
      iord      = 1'b0;
      irwrite   = 1'b0;
      pc_en     = 1'b0;
      pcsrc     = PCSRC_ALU;
      alusrca   = 1'b0;
      alusrcb   = ALUB_REGB;
      aluop     = 3'd0;
      regdst    = 1'b0;
      memtoreg  = 1'b0;
      regwrite  = 1'b0;
      retire    = 1'b0;
      illegal   = 1'b0;
      case (state)
         FETCH: begin
            mem_req = 1'b1;
            irwrite = mem_ready;
            pc_en   = mem_ready;
            alusrcb = ALUB_FOUR;
            aluop   = ALU_ADD;
            if (mem_ready) state_nxt = DECODE;
         end
         DECODE: begin
            alusrcb = ALUB_IMMSH;
            aluop   = ALU_ADD;
            case (op)
               OP_LW, OP_SW:                      state_nxt = MEMADR;
               OP_RTYPE:                          state_nxt = RTEXE;
               OP_BEQ:                            state_nxt = BEQ;
               OP_ADDI, OP_ORI, OP_ANDI, OP_SLTI: state_nxt = IMMEXE;
               OP_J:                              state_nxt = JUMP;
               default:                           state_nxt = ILLEGAL;
            endcase
         end
         MEMADR: begin
            alusrca   = 1'b1;
            alusrcb   = ALUB_IMM;
            aluop     = ALU_ADD;
            state_nxt = (op == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready) state_nxt = MEMWB;
         end
         MEMWB: begin
            regwrite  = 1'b1;
            memtoreg  = 1'b1;
            retire    = 1'b1;
            state_nxt = FETCH;
         end
         MEMWR: begin
            mem_req  = 1'b1;
            memwrite = 1'b1;
            iord     = 1'b1;
            retire   = mem_ready;
            if (mem_ready) state_nxt = FETCH;
         end
         RTEXE: begin
            alusrca   = 1'b1;
            alusrcb   = ALUB_REGB;
            aluop     = ALU_NO_USE;
            state_nxt = RTWB;
         end
         RTWB: begin
            regwrite  = 1'b1;
            regdst    = 1'b1;
            retire    = 1'b1;
            state_nxt = FETCH;
         end
         BEQ: begin
            alusrca   = 1'b1;
            alusrcb   = ALUB_REGB;
            aluop     = ALU_SUB;
            pcsrc     = PCSRC_ALUOUT;
            pc_en     = zero;
            retire    = 1'b1;
            state_nxt = FETCH;
         end
         IMMEXE: begin
            alusrca   = 1'b1;
            alusrcb   = ALUB_IMM;
            aluop     = imm_aluop;
            state_nxt = IMMWB;
         end
         IMMWB: begin
            regwrite  = 1'b1;
            retire    = 1'b1;
            state_nxt = FETCH;
         end
         JUMP: begin
            pcsrc     = PCSRC_JUMP;
            pc_en     = 1'b1;
            retire    = 1'b1;
            state_nxt = FETCH;
         end
         ILLEGAL: begin
            illegal   = 1'b1;
            state_nxt = FETCH;
         end
         default: state_nxt = FETCH;
      endcase
      if (!resetn) begin
         mem_req  = 1'b0;
         memwrite = 1'b0;
         iord     = 1'b0;
         irwrite  = 1'b0;
         pc_en    = 1'b0;
         pcsrc    = 2'b00;
         alusrca  = 1'b0;
         alusrcb  = 2'b00;
         aluop    = 3'd0;
         regdst   = 1'b0;
         memtoreg = 1'b0;
         regwrite = 1'b0;
         retire   = 1'b0;
         illegal  = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for the multi-cycle control FSM.
module tb_multicycle_ctrl;
   import multicycle_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [5:0] op = 6'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, memwrite, iord, irwrite, pc_en;
   logic [1:0] pcsrc, alusrcb;
   logic       alusrca;
   logic [2:0] aluop;
   logic       regdst, memtoreg, regwrite, retire, illegal;
   logic [3:0] state_o;

   int checks = 0;
   int failures = 0;

   multicycle_ctrl dut (
      .clk(clk), .resetn(resetn), .op(op), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
      .pc_en(pc_en), .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb),
      .aluop(aluop), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
      .retire(retire), .illegal(illegal), .state_o(state_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       mem_req;
      logic       memwrite;
      logic       iord;
      logic       irwrite;
      logic       pc_en;
      logic [1:0] pcsrc;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [2:0] aluop;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       retire;
      logic       illegal;
      logic [3:0] state;
   } exp_t;

   typedef struct {
      logic        rstn;
      logic [5:0]  op;
      logic        zero;
      logic        rdy;
      ctrl_state_t st;
   } vec_t;

   vec_t vecs[$];
   exp_t sb[$];

   task automatic add(input logic rstn, input logic [5:0] o, input logic z,
                      input logic r, input ctrl_state_t st);
      vec_t v;
      v.rstn = rstn; v.op = o; v.zero = z; v.rdy = r; v.st = st;
      vecs.push_back(v);
   endtask

   // Expected outputs for a state, taken from the state/output table
   function automatic exp_t exp_for(input vec_t v);
      exp_t e;
      e = '0;
      if (!v.rstn) return e;
      e.state = v.st;
      case (v.st)
         FETCH:   begin e.mem_req = 1; e.irwrite = v.rdy; e.pc_en = v.rdy;
                        e.alusrcb = 2'b01; e.aluop = ALU_ADD; end
         DECODE:  begin e.alusrcb = 2'b11; e.aluop = ALU_ADD; end
         MEMADR:  begin e.alusrca = 1; e.alusrcb = 2'b10; e.aluop = ALU_ADD; end
         MEMRD:   begin e.mem_req = 1; e.iord = 1; end
         MEMWB:   begin e.regwrite = 1; e.memtoreg = 1; e.retire = 1; end
         MEMWR:   begin e.mem_req = 1; e.memwrite = 1; e.iord = 1; e.retire = v.rdy; end
         RTEXE:   begin e.alusrca = 1; e.alusrcb = 2'b00; e.aluop = ALU_NO_USE; end
         RTWB:    begin e.regwrite = 1; e.regdst = 1; e.retire = 1; end
         BEQ:     begin e.alusrca = 1; e.aluop = ALU_SUB; e.pcsrc = 2'b01;
                        e.pc_en = v.zero; e.retire = 1; end
         IMMEXE:  begin
                     e.alusrca = 1; e.alusrcb = 2'b10;
                     if (v.op == 6'b001101)      e.aluop = ALU_OR;
                     else if (v.op == 6'b001100) e.aluop = ALU_AND;
                     else if (v.op == 6'b001010) e.aluop = ALU_SLT;
                     else                        e.aluop = ALU_ADD;
                  end
         IMMWB:   begin e.regwrite = 1; e.retire = 1; end
         JUMP:    begin e.pcsrc = 2'b10; e.pc_en = 1; e.retire = 1; end
         ILLEGAL: begin e.illegal = 1; end
         default: e = '0;
      endcase
      return e;
   endfunction

   function automatic exp_t sample();
      exp_t g;
      g = {mem_req, memwrite, iord, irwrite, pc_en, pcsrc, alusrca, alusrcb,
           aluop, regdst, memtoreg, regwrite, retire, illegal, state_o};
      return g;
   endfunction

   initial begin
      exp_t e, g;
      // Reset, then LW with zero-wait memory
      add(0, OP_LW, 0, 1, FETCH);
      add(0, OP_LW, 0, 1, FETCH);
      add(1, OP_LW, 0, 1, FETCH);
      add(1, OP_LW, 0, 1, DECODE);
      add(1, OP_LW, 0, 1, MEMADR);
      add(1, OP_LW, 0, 1, MEMRD);
      add(1, OP_LW, 0, 1, MEMWB);
      // SW with three wait cycles in MEMWR
      add(1, OP_SW, 0, 1, FETCH);
      add(1, OP_SW, 0, 0, DECODE);
      add(1, OP_SW, 0, 0, MEMADR);
      add(1, OP_SW, 0, 0, MEMWR);
      add(1, OP_SW, 0, 0, MEMWR);
      add(1, OP_SW, 0, 0, MEMWR);
      add(1, OP_SW, 0, 1, MEMWR);
      // BEQ taken, then not taken
      add(1, OP_BEQ, 1, 1, FETCH);
      add(1, OP_BEQ, 0, 0, DECODE);
      add(1, OP_BEQ, 1, 0, BEQ);
      add(1, OP_BEQ, 0, 1, FETCH);
      add(1, OP_BEQ, 1, 1, DECODE);
      add(1, OP_BEQ, 0, 1, BEQ);
      // ORI
      add(1, OP_ORI, 0, 1, FETCH);
      add(1, OP_ORI, 0, 1, DECODE);
      add(1, OP_ORI, 0, 1, IMMEXE);
      add(1, OP_ORI, 0, 1, IMMWB);
      // Unsupported opcode then J
      add(1, 6'b111111, 0, 1, FETCH);
      add(1, 6'b111111, 0, 1, DECODE);
      add(1, 6'b111111, 0, 1, ILLEGAL);
      add(1, OP_J, 0, 1, FETCH);
      add(1, OP_J, 0, 1, DECODE);
      add(1, OP_J, 0, 1, JUMP);
      // R-type with one fetch wait cycle
      add(1, OP_RTYPE, 0, 0, FETCH);
      add(1, OP_RTYPE, 0, 1, FETCH);
      add(1, OP_RTYPE, 0, 1, DECODE);
      add(1, OP_RTYPE, 0, 1, RTEXE);
      add(1, OP_RTYPE, 0, 1, RTWB);
      // SW stalled in MEMWR, aborted by reset
      add(1, OP_SW, 0, 1, FETCH);
      add(1, OP_SW, 0, 1, DECODE);
      add(1, OP_SW, 0, 0, MEMADR);
      add(1, OP_SW, 0, 0, MEMWR);
      add(0, OP_SW, 0, 0, FETCH);
      add(0, OP_SW, 0, 0, FETCH);
      add(0, OP_SW, 0, 0, FETCH);
      add(1, OP_ADDI, 0, 0, FETCH);
      // ADDI, ANDI, SLTI
      add(1, OP_ADDI, 0, 1, FETCH);
      add(1, OP_ADDI, 0, 1, DECODE);
      add(1, OP_ADDI, 0, 1, IMMEXE);
      add(1, OP_ADDI, 0, 1, IMMWB);
      add(1, OP_ANDI, 0, 1, FETCH);
      add(1, OP_ANDI, 0, 1, DECODE);
      add(1, OP_ANDI, 0, 1, IMMEXE);
      add(1, OP_ANDI, 0, 1, IMMWB);
      add(1, OP_SLTI, 0, 1, FETCH);
      add(1, OP_SLTI, 0, 1, DECODE);
      add(1, OP_SLTI, 0, 1, IMMEXE);
      add(1, OP_SLTI, 0, 1, IMMWB);
      // LW with one MEMRD wait cycle
      add(1, OP_LW, 0, 1, FETCH);
      add(1, OP_LW, 0, 1, DECODE);
      add(1, OP_LW, 0, 1, MEMADR);
      add(1, OP_LW, 0, 0, MEMRD);
      add(1, OP_LW, 0, 1, MEMRD);
      add(1, OP_LW, 0, 1, MEMWB);

      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk);
         #1;
         resetn    = vecs[i].rstn;
         op        = vecs[i].op;
         zero      = vecs[i].zero;
         mem_ready = vecs[i].rdy;
         sb.push_back(exp_for(vecs[i]));
         @(negedge clk);
         e = sb.pop_front();
         g = sample();
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL vec%0d outputs got=%h expected=%h (state got %0d expected %0d)",
                     i, g, e, g.state, e.state);
         end
         if (retire && illegal) begin
            failures++;
            $display("FAIL vec%0d retire_and_illegal both high", i);
         end
      end

      // LW latency with n wait cycles in MEMRD: must be 5 + n
      for (int n = 0; n < 4; n++) begin
         int w, cycles;
         bit done;
         w = 0; cycles = 0; done = 0;
         for (int c = 0; c < 20 && !done; c++) begin
            @(posedge clk);
            #1;
            op = OP_LW; zero = 0;
            if (state_o == MEMRD && w < n) begin
               mem_ready = 0; w++;
            end else begin
               mem_ready = 1;
            end
            cycles++;
            @(negedge clk);
            if (retire) done = 1;
         end
         checks++;
         if (!done || cycles != 5 + n) begin
            failures++;
            $display("FAIL lw_latency_wait%0d got=%0d cycles (retired=%0d) expected=%0d",
                     n, cycles, done, 5 + n);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style control FSM that sequences the shared single-port-memory datapath of the multi-cycle MIPS core, one instruction at a time: fetch, decode, execute, memory, writeback.
- Consumes the opcode from the instruction register plus the ALU zero flag.
- Drives every datapath select/enable, and stalls on a memory ready handshake.
- Covers the same opcode set as the single-cycle main decoder: R-type, LW, SW, BEQ, ADDI, ORI, ANDI, SLTI, J.

Parameters:
- None. Widths are fixed by the shared package types.

Ports:
- clk  in  1  core clock; all state updates on its rising edge
- resetn  in  1  asynchronous active-low reset
- op  in  u6  opcode field of instruction register
- zero  in  u1  ALU zero flag, valid in BEQ state
- mem_ready  in  u1  memory completes current access this cycle
- mem_req  out  u1  memory access request
- memwrite  out  u1  request is a write
- iord  out  u1  address select: 0 = PC, 1 = ALUOut
- irwrite  out  u1  load instruction register
- pc_en  out  u1  PC load enable (pcwrite OR branch-taken)
- pcsrc  out  u2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alusrca  out  u1  ALU A: 0 = PC, 1 = reg A
- alusrcb  out  u2  ALU B: 00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2
- aluop  out  u3  package ALU_* code
- regdst  out  u1  dest reg: 0 = rt, 1 = rd
- memtoreg  out  u1  writeback data: 0 = ALUOut, 1 = MDR
- regwrite  out  u1  register file write enable
- retire  out  u1  1-cycle pulse when an instruction completes
- illegal  out  u1  1-cycle pulse when the opcode is unsupported
- state_o  out  u4  current state, debug only

Behaviour:
- Reset:
  - State resets asynchronously to FETCH.
  - While resetn = 0, every output except state_o is forced to 0.
  - After release, FETCH outputs apply from the same cycle.
- Outputs decode from state only, except:
  - pc_en in FETCH = mem_ready.
  - pc_en in BEQ = zero.
- States and required outputs (any output not listed is 0):
  - FETCH: mem_req, iord = 0, irwrite = mem_ready, alusrca = 0, alusrcb = 01, aluop = ALU_ADD, pcsrc = 00. Stay while mem_ready = 0; otherwise go to DECODE.
  - DECODE: alusrca = 0, alusrcb = 11, aluop = ALU_ADD (precomputes branch target into ALUOut). Next state by op:
    - LW/SW go to MEMADR
    - RTYPE goes to RTEXE
    - BEQ goes to BEQ
    - ADDI/ORI/ANDI/SLTI go to IMMEXE
    - J goes to JUMP
    - any other op goes to ILLEGAL
  - MEMADR: alusrca = 1, alusrcb = 10, aluop = ALU_ADD. LW goes to MEMRD; SW goes to MEMWR.
  - MEMRD: mem_req, iord = 1. Stay while mem_ready = 0; otherwise go to MEMWB.
  - MEMWB: regwrite, memtoreg = 1, regdst = 0, retire. Go to FETCH.
  - MEMWR: mem_req, memwrite, iord = 1. While mem_ready = 0, hold with outputs unchanged. On mem_ready = 1, assert retire and go to FETCH.
  - RTEXE: alusrca = 1, alusrcb = 00, aluop = ALU_NO_USE (ALU decoder uses funct). Go to RTWB.
  - RTWB: regwrite, regdst = 1, memtoreg = 0, retire. Go to FETCH.
  - BEQ: alusrca = 1, alusrcb = 00, aluop = ALU_SUB, pcsrc = 01, pc_en = zero, retire. Go to FETCH.
  - IMMEXE: alusrca = 1, alusrcb = 10, aluop by op: ADDI = ALU_ADD, ORI = ALU_OR, ANDI = ALU_AND, SLTI = ALU_SLT. Go to IMMWB.
  - IMMWB: regwrite, regdst = 0, memtoreg = 0, retire. Go to FETCH.
  - JUMP: pcsrc = 10, pc_en = 1, retire. Go to FETCH.
  - ILLEGAL: illegal = 1 for one cycle; PC already advanced, so the instruction is skipped. Go to FETCH.
- Rules:
  - op is sampled in DECODE, MEMADR and IMMEXE. The instruction register is stable there because irwrite is only high in FETCH.
  - mem_ready is ignored outside FETCH, MEMRD and MEMWR.
  - Wait states have no timeout.
  - retire and illegal are never high together.
  - Asynchronous reset mid-instruction aborts to FETCH. No partial register or memory write is issued once resetn is low.
- Latency with zero-wait memory:
  - LW 5 cycles
  - SW, R-type and immediate ops 4 cycles
  - BEQ and J 3 cycles
  - each extra memory wait cycle adds 1

Decomposition:
- common.svh / shared package holds:
  - the opcode macros already in use
  - ALU_ADD, ALU_OR, ALU_AND, ALU_SLT, ALU_NO_USE, and the new ALU_SUB
  - a state enum ctrl_state_t (4-bit: FETCH = 0 ... ILLEGAL = 12)
  - PCSRC_* and ALUB_* constants
- One sub-module, imm_aluop_dec: combinational mapping from op to aluop for IMMEXE. Everything else stays in one module: state register, next-state logic, output decode.

Test Plan:
- Reset: hold resetn = 0 for 3 cycles mid-MEMWR → all outputs 0, state_o = 0. Release → mem_req = 1, iord = 0 in the next cycle.
- LW (op = 100011), mem_ready = 1 always → states FETCH→DECODE→MEMADR→MEMRD→MEMWB→FETCH. regwrite = memtoreg = 1 and retire = 1 in cycle 5 only.
- SW (op = 101011), mem_ready low for 3 cycles in MEMWR → memwrite held 4 cycles, retire on the 4th, regwrite never 1.
- BEQ (op = 000100): zero = 1 → pc_en = 1, pcsrc = 01 in cycle 3. Repeat with zero = 0 → pc_en = 0. Both take 3 cycles.
- ORI (op = 001101) → IMMEXE aluop = ALU_OR, alusrcb = 10. IMMWB regwrite = 1, regdst = 0. Total 4 cycles.
- op = 111111 → illegal pulses 1 cycle after DECODE, no regwrite/memwrite, then FETCH. A following J (op = 000010) gives pc_en = 1, pcsrc = 10.
